// File: rtl/key_entry_buffer_if.sv
// key_entry_buffer_if: keypad key-entry bus between the key-strobe/commit
// source (master) and the key-entry buffer (slave).
//   shift       : one-cycle key strobe
//   key         : key code, sampled when shift=1
//   commit      : one-cycle request to accept the current entry
//   key_buffer  : stored digits, digit i at [i*KEY_W +: KEY_W], digit 0 newest
//   digit_count : digits entered since last clear/commit (saturating)
//   full        : digit_count == DIGITS
//   time_valid  : low four digits form a legal HH:MM
//   accept      : one-cycle pulse, commit succeeded
//   reject      : one-cycle pulse, commit refused
//   key_err     : one-cycle pulse, illegal key code strobed
interface key_entry_buffer_if #(
    parameter int DIGITS = 4,
    parameter int KEY_W  = 4
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic                    shift;
    logic [KEY_W-1:0]        key;
    logic                    commit;
    logic [DIGITS*KEY_W-1:0] key_buffer;
    logic [CNT_W-1:0]        digit_count;
    logic                    full;
    logic                    time_valid;
    logic                    accept;
    logic                    reject;
    logic                    key_err;

    modport master (
        output shift, key, commit,
        input  key_buffer, digit_count, full, time_valid, accept, reject, key_err
    );

    modport slave (
        input  shift, key, commit,
        output key_buffer, digit_count, full, time_valid, accept, reject, key_err
    );
endinterface

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: keypad key-entry register for the alarm clock.
// Keeps the last DIGITS decimal keys in a shift chain (digit 0 = newest),
// handles clear and backspace keys, counts entered digits, checks the low
// four digits as HH:MM and runs the commit/accept/reject handshake.
// Ports:
//   clock : system clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : key_entry_buffer_if slave (strobe/key/commit in, buffer/status out)
module key_entry_buffer #(
    parameter int DIGITS   = 4,
    parameter int KEY_W    = 4,
    parameter int NO_KEY   = 10,
    parameter int CLR_KEY  = 11,
    parameter int BKSP_KEY = 12
) (
    input  logic                clock,
    input  logic                reset,
    key_entry_buffer_if.slave   bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    localparam logic [KEY_W-1:0] K_NINE = KEY_W'(9);
    localparam logic [KEY_W-1:0] K_NO   = KEY_W'(NO_KEY);
    localparam logic [KEY_W-1:0] K_CLR  = KEY_W'(CLR_KEY);
    localparam logic [KEY_W-1:0] K_BKSP = KEY_W'(BKSP_KEY);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(DIGITS);

    logic [DIGITS-1:0][KEY_W-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]             count_q,  count_d;
    logic                         accept_q, accept_d;
    logic                         reject_q, reject_d;
    logic                         key_err_q, key_err_d;
    logic                         full;
    logic                         time_valid;

    assign full = (count_q == C_MAX);

    generate
        if (DIGITS >= 4) begin : g_hhmm
            logic [KEY_W-1:0] ms_hr, ls_hr, ms_min, ls_min;
            assign ms_hr  = digits_q[3];
            assign ls_hr  = digits_q[2];
            assign ms_min = digits_q[1];
            assign ls_min = digits_q[0];
            // Hours 00..23, minutes 00..59; 2x hours need LS_HR <= 3.
            assign time_valid = (ms_hr <= KEY_W'(2)) && (ls_hr <= K_NINE) &&
                                (ms_min <= KEY_W'(5)) && (ls_min <= K_NINE) &&
                                ((ms_hr < KEY_W'(2)) || (ls_hr <= KEY_W'(3)));
        end else begin : g_no_hhmm
            assign time_valid = 1'b1;
        end
    endgenerate

    always_comb begin
        digits_d  = digits_q;
        count_d   = count_q;
        accept_d  = 1'b0;
        reject_d  = 1'b0;
        key_err_d = 1'b0;
        if (bus.shift) begin
            // A strobe always wins; a simultaneous commit is dropped.
            if (bus.key <= K_NINE) begin
                for (int i = DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
                digits_d[0] = bus.key;
                if (!full) count_d = count_q + CNT_W'(1);
            end else if (bus.key == K_NO) begin
                // idle code: nothing to do
            end else if (bus.key == K_CLR) begin
                digits_d = '0;
                count_d  = '0;
            end else if (bus.key == K_BKSP) begin
                // Digits shifted out by saturation are gone; top refills with 0.
                if (count_q != '0) begin
                    for (int i = 0; i < DIGITS - 1; i++) digits_d[i] = digits_q[i+1];
                    digits_d[DIGITS-1] = '0;
                    count_d = count_q - CNT_W'(1);
                end
            end else begin
                key_err_d = 1'b1;
            end
        end else if (bus.commit) begin
            // Digits are kept on accept so the loader can sample key_buffer.
            if (full && time_valid) begin
                accept_d = 1'b1;
                count_d  = '0;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            digits_q  <= '0;
            count_q   <= '0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            count_q   <= count_d;
            accept_q  <= accept_d;
            reject_q  <= reject_d;
            key_err_q <= key_err_d;
        end
    end

    assign bus.key_buffer  = digits_q;
    assign bus.digit_count = count_q;
    assign bus.full        = full;
    assign bus.time_valid  = time_valid;
    assign bus.accept      = accept_q;
    assign bus.reject      = reject_q;
    assign bus.key_err     = key_err_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: a 4-digit and a 6-digit instance share stimulus.
// The reference model keeps each entry as a decimal number (shift-in is
// v*10+k mod 10^D, backspace is v/10) and judges HH:MM from hours/minutes.
module tb_key_entry_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    key_entry_buffer_if #(.DIGITS(4), .KEY_W(4)) k4 ();
    key_entry_buffer_if #(.DIGITS(6), .KEY_W(4)) k6 ();

    key_entry_buffer #(.DIGITS(4)) u4 (.clock(clk), .reset(rst_n), .bus(k4));
    key_entry_buffer #(.DIGITS(6)) u6 (.clock(clk), .reset(rst_n), .bus(k6));

    // reference model state, index 0 = 4-digit, 1 = 6-digit
    longint mv[2];
    int     mc[2];
    bit     ea[2], er[2];
    bit     ek;

    function automatic int dg(input int n);
        return (n == 0) ? 4 : 6;
    endfunction

    function automatic longint p10(input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit exp_tv(input int n);
        longint hh = (mv[n] / 100) % 100;
        longint mm = mv[n] % 100;
        return (hh <= 23) && (mm <= 59);
    endfunction

    function automatic logic [23:0] exp_buf(input int n);
        logic [23:0] b = '0;
        longint v = mv[n];
        for (int i = 0; i < dg(n); i++) begin
            b[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic model_step(input bit r, input bit sh, input int k, input bit cm);
        ek = 1'b0;
        for (int n = 0; n < 2; n++) begin
            bit tv = exp_tv(n);
            ea[n] = 1'b0;
            er[n] = 1'b0;
            if (!r) begin
                mv[n] = 0;
                mc[n] = 0;
            end else if (sh) begin
                if (k <= 9) begin
                    mv[n] = (mv[n] * 10 + k) % p10(dg(n));
                    if (mc[n] < dg(n)) mc[n]++;
                end else if (k == 11) begin
                    mv[n] = 0;
                    mc[n] = 0;
                end else if (k == 12) begin
                    if (mc[n] > 0) begin
                        mv[n] = mv[n] / 10;
                        mc[n]--;
                    end
                end else if (k != 10) begin
                    ek = 1'b1;
                end
            end else if (cm) begin
                if (mc[n] == dg(n) && tv) begin
                    ea[n] = 1'b1;
                    mc[n] = 0;
                end else begin
                    er[n] = 1'b1;
                end
            end
        end
    endtask

    // one clock: drive on negedge, update model at posedge, return 1ns later
    task automatic drive(input bit r, input bit sh, input int k, input bit cm);
        @(negedge clk);
        rst_n     = r;
        k4.shift  = sh;  k6.shift  = sh;
        k4.key    = 4'(k); k6.key  = 4'(k);
        k4.commit = cm;  k6.commit = cm;
        @(posedge clk);
        model_step(r, sh, k, cm);
        #1;
    endtask

    task automatic test_reset;
        drive(0, 1, 7, 1);
        drive(0, 0, 0, 0);
        total++; if (k4.key_buffer !== 16'h0) $display("FAIL reset_buf4 got %h exp 0000", k4.key_buffer); else passed++;
        total++; if (k4.digit_count !== 3'd0) $display("FAIL reset_cnt4 got %0d exp 0", k4.digit_count); else passed++;
        total++; if ({k4.accept, k4.reject, k4.key_err} !== 3'b000) $display("FAIL reset_pulses got %b exp 000", {k4.accept, k4.reject, k4.key_err}); else passed++;
        total++; if ({k4.full, k4.time_valid} !== 2'b01) $display("FAIL reset_full_tv got %b exp 01", {k4.full, k4.time_valid}); else passed++;
        total++; if (k6.key_buffer !== 24'h0) $display("FAIL reset_buf6 got %h exp 000000", k6.key_buffer); else passed++;
    endtask

    task automatic test_shift;
        int keys[4] = '{1, 2, 3, 4};
        foreach (keys[i]) drive(1, 1, keys[i], 0);
        total++; if (k4.key_buffer !== 16'h1234) $display("FAIL shift_1234 got %h exp 1234", k4.key_buffer); else passed++;
        total++; if (k4.digit_count !== 3'd4 || k4.full !== 1'b1) $display("FAIL shift_cnt got %0d/%b exp 4/1", k4.digit_count, k4.full); else passed++;
        total++; if (k4.time_valid !== 1'b1) $display("FAIL shift_tv1234 got %b exp 1", k4.time_valid); else passed++;
        drive(1, 1, 5, 0);
        total++; if (k4.key_buffer !== 16'h2345 || k4.digit_count !== 3'd4) $display("FAIL shift_2345 got %h/%0d exp 2345/4", k4.key_buffer, k4.digit_count); else passed++;
        total++; if (k4.time_valid !== 1'b1) $display("FAIL shift_tv2345 got %b exp 1", k4.time_valid); else passed++;
        drive(1, 1, 9, 0);
        total++; if (k4.key_buffer !== 16'h3459 || k4.time_valid !== 1'b0) $display("FAIL shift_3459 got %h/%b exp 3459/0", k4.key_buffer, k4.time_valid); else passed++;
        total++; if (k6.key_buffer !== 24'h123459 || k6.digit_count !== 3'd6 || k6.full !== 1'b1) $display("FAIL shift6 got %h/%0d/%b exp 123459/6/1", k6.key_buffer, k6.digit_count, k6.full); else passed++;
        total++; if (k6.time_valid !== 1'b0) $display("FAIL shift6_tv got %b exp 0", k6.time_valid); else passed++;
    endtask

    task automatic test_backspace;
        logic [15:0] eb[4] = '{16'h0012, 16'h0001, 16'h0000, 16'h0000};
        int          ec[4] = '{2, 1, 0, 0};
        drive(1, 1, 11, 0);
        drive(1, 1, 1, 0); drive(1, 1, 2, 0); drive(1, 1, 3, 0);
        total++; if (k4.key_buffer !== 16'h0123 || k4.digit_count !== 3'd3) $display("FAIL bksp_load got %h/%0d exp 0123/3", k4.key_buffer, k4.digit_count); else passed++;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 12, 0);
            total++;
            if (k4.key_buffer !== eb[i] || int'(k4.digit_count) != ec[i] || k4.key_err !== 1'b0)
                $display("FAIL bksp_%0d got %h/%0d/%b exp %h/%0d/0", i, k4.key_buffer, k4.digit_count, k4.key_err, eb[i], ec[i]);
            else passed++;
        end
    endtask

    task automatic test_commit;
        drive(1, 1, 2, 0); drive(1, 1, 4, 0); drive(1, 1, 0, 0); drive(1, 1, 0, 0);
        drive(1, 0, 0, 1);
        total++; if ({k4.reject, k4.accept} !== 2'b10 || k4.digit_count !== 3'd4) $display("FAIL commit_rej got r%b a%b c%0d exp r1 a0 c4", k4.reject, k4.accept, k4.digit_count); else passed++;
        total++; if (k4.key_buffer !== 16'h2400) $display("FAIL commit_rej_buf got %h exp 2400", k4.key_buffer); else passed++;
        drive(1, 0, 0, 0);
        total++; if (k4.reject !== 1'b0) $display("FAIL rej_one_cycle got %b exp 0", k4.reject); else passed++;
        drive(1, 1, 11, 0);
        total++; if (k4.key_buffer !== 16'h0 || k4.digit_count !== 3'd0) $display("FAIL clr got %h/%0d exp 0000/0", k4.key_buffer, k4.digit_count); else passed++;
        drive(1, 1, 0, 0); drive(1, 1, 7, 0); drive(1, 1, 3, 0); drive(1, 1, 0, 0);
        drive(1, 0, 0, 1);
        total++; if ({k4.accept, k4.reject} !== 2'b10 || k4.digit_count !== 3'd0) $display("FAIL commit_acc got a%b r%b c%0d exp a1 r0 c0", k4.accept, k4.reject, k4.digit_count); else passed++;
        total++; if (k4.key_buffer !== 16'h0730) $display("FAIL commit_acc_buf got %h exp 0730", k4.key_buffer); else passed++;
        total++; if ({k6.accept, k6.reject} !== 2'b01) $display("FAIL commit6_notfull got a%b r%b exp a0 r1", k6.accept, k6.reject); else passed++;
        drive(1, 0, 0, 0);
        total++; if (k4.accept !== 1'b0) $display("FAIL acc_one_cycle got %b exp 0", k4.accept); else passed++;
    endtask

    task automatic test_key_err;
        drive(1, 1, 13, 0);
        total++; if (k4.key_err !== 1'b1 || k4.key_buffer !== 16'h0730) $display("FAIL key_err got %b/%h exp 1/0730", k4.key_err, k4.key_buffer); else passed++;
        drive(1, 0, 0, 0);
        total++; if (k4.key_err !== 1'b0) $display("FAIL key_err_one_cycle got %b exp 0", k4.key_err); else passed++;
        drive(1, 1, 10, 0);
        total++; if ({k4.key_err, k4.accept, k4.reject} !== 3'b000 || k4.key_buffer !== 16'h0730 || k4.digit_count !== 3'd0)
            $display("FAIL no_key got p%b %h/%0d exp p000 0730/0", {k4.key_err, k4.accept, k4.reject}, k4.key_buffer, k4.digit_count); else passed++;
        drive(1, 1, 5, 1);
        total++; if (k4.key_buffer !== 16'h7305 || k4.digit_count !== 3'd1 || {k4.accept, k4.reject} !== 2'b00)
            $display("FAIL shift_commit got %h/%0d a%b r%b exp 7305/1 a0 r0", k4.key_buffer, k4.digit_count, k4.accept, k4.reject); else passed++;
    endtask

    task automatic test_reset_mid;
        drive(1, 1, 11, 0); drive(1, 1, 1, 0); drive(1, 1, 2, 0);
        total++; if (k4.digit_count !== 3'd2) $display("FAIL mid_cnt got %0d exp 2", k4.digit_count); else passed++;
        drive(0, 1, 3, 0);
        total++; if (k4.key_buffer !== 16'h0 || k4.digit_count !== 3'd0 || {k4.accept, k4.reject, k4.key_err} !== 3'b000)
            $display("FAIL mid_reset got %h/%0d p%b exp 0000/0 p000", k4.key_buffer, k4.digit_count, {k4.accept, k4.reject, k4.key_err}); else passed++;
        total++; if (k6.key_buffer !== 24'h0 || k6.digit_count !== 3'd0) $display("FAIL mid_reset6 got %h/%0d exp 000000/0", k6.key_buffer, k6.digit_count); else passed++;
    endtask

    task automatic test_random;
        logic [23:0] gb[2], eb;
        int          gc[2];
        logic        gf[2], gt[2], ga[2], gr[2];
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit r  = ($urandom_range(0, 63) != 0);
            bit sh = ($urandom_range(0, 3) != 0);
            bit cm = ($urandom_range(0, 3) == 0);
            int k  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            drive(r, sh, k, cm);
            gb[0] = 24'(k4.key_buffer); gb[1] = k6.key_buffer;
            gc[0] = int'(k4.digit_count); gc[1] = int'(k6.digit_count);
            gf[0] = k4.full; gf[1] = k6.full;
            gt[0] = k4.time_valid; gt[1] = k6.time_valid;
            ga[0] = k4.accept; ga[1] = k6.accept;
            gr[0] = k4.reject; gr[1] = k6.reject;
            for (int n = 0; n < 2; n++) begin
                eb = exp_buf(n);
                total++; if (gb[n] !== eb) $display("FAIL rnd_buf d%0d cyc %0d got %h exp %h", dg(n), cyc, gb[n], eb); else passed++;
                total++; if (gc[n] != mc[n]) $display("FAIL rnd_cnt d%0d cyc %0d got %0d exp %0d", dg(n), cyc, gc[n], mc[n]); else passed++;
                total++; if (gf[n] !== (mc[n] == dg(n))) $display("FAIL rnd_full d%0d cyc %0d got %b exp %b", dg(n), cyc, gf[n], mc[n] == dg(n)); else passed++;
                total++; if (gt[n] !== exp_tv(n)) $display("FAIL rnd_tv d%0d cyc %0d got %b exp %b", dg(n), cyc, gt[n], exp_tv(n)); else passed++;
                total++; if (ga[n] !== ea[n] || gr[n] !== er[n]) $display("FAIL rnd_handshake d%0d cyc %0d got a%b r%b exp a%b r%b", dg(n), cyc, ga[n], gr[n], ea[n], er[n]); else passed++;
            end
            total++; if (k4.key_err !== ek || k6.key_err !== ek) $display("FAIL rnd_key_err cyc %0d got %b%b exp %b", cyc, k4.key_err, k6.key_err, ek); else passed++;
        end
    endtask

    initial begin
        k4.shift = 0; k4.key = '0; k4.commit = 0;
        k6.shift = 0; k6.key = '0; k6.commit = 0;
        mv[0] = 0; mv[1] = 0; mc[0] = 0; mc[1] = 0;
        ea[0] = 0; ea[1] = 0; er[0] = 0; er[1] = 0; ek = 0;
        test_reset;
        test_shift;
        test_backspace;
        test_commit;
        test_key_err;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
